// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_fetch
// Brief    : Byte-addressed instruction memory with a multi-cycle fetch
//            handshake, a one-word last-fetch buffer and a byte load port.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_fetch #(
    parameter int ADDR_W    = 10,
    parameter int BYTES     = 4,
    parameter int FETCH_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc,
    input  logic                 read,
    output logic [8*BYTES-1:0]   instruction,
    output logic                 busywait,
    output logic                 misaligned,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [7:0]           load_data
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam int                CNT_W      = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam logic [ADDR_W-1:0] c_off_mask = ADDR_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(FETCH_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_tag;
    logic [CNT_W-1:0]    r_cnt;
    logic [8*BYTES-1:0]  r_instr;
    logic [7:0]          r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0]   w_word_addr;
    logic                w_hit;
    logic                w_load_in_tag;
    logic [8*BYTES-1:0]  w_rd_word;

    // PC bits above the array are intentionally dropped so addresses wrap.
    wire w_unused_pc = &{1'b0, pc[31:ADDR_W]};

    assign w_word_addr   = pc[ADDR_W-1:0] & ~c_off_mask;
    assign w_hit         = r_valid && (r_tag == w_word_addr);
    assign w_load_in_tag = load_en && ((load_addr & ~c_off_mask) == r_tag);

    assign busywait    = !reset && ((r_state == S_IDLE && read && !w_hit) ||
                                    (r_state == S_FETCH));
    assign misaligned  = !reset && read && ((pc[ADDR_W-1:0] & c_off_mask) != '0);
    assign instruction = r_instr;

    // Little-endian word assembly; the tag is aligned so OR-ing the offset is exact.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_rd_word[8*i +: 8] = r_mem[r_tag | ADDR_W'(i)];
        end
    end

    // Storage is deliberately not reset; only the load port writes it.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_cnt   <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A concurrent load takes the cycle; the request waits.
                    if (read && !w_hit && !load_en) begin
                        r_tag   <= w_word_addr;
                        r_cnt   <= c_cnt_init;
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_instr <= w_rd_word;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A write into the buffered word invalidates it, beating a same-edge capture.
            if (w_load_in_tag) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_fetch
// Brief    : Scoreboard bench for instr_mem_fetch (fetch latency, buffer, loads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_fetch;

    localparam int ADDR_W    = 10;
    localparam int BYTES     = 4;
    localparam int FETCH_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic              read;
    logic [31:0]       instruction;
    logic              busywait;
    logic              misaligned;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;

    instr_mem_fetch #(
        .ADDR_W    (ADDR_W),
        .BYTES     (BYTES),
        .FETCH_LAT (FETCH_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .read        (read),
        .instruction (instruction),
        .busywait    (busywait),
        .misaligned  (misaligned),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        int          busy;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   busy_run = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count busy cycles of the pending request; pop and compare on its first ready cycle.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else if (read && sb.size() > 0) begin
            if (busywait) begin
                busy_run++;
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_instr"}, instruction, e.instr);
                chk({e.tag, "_busy"}, 32'(busy_run), 32'(e.busy));
                chk({e.tag, "_mis"}, {31'd0, misaligned}, {31'd0, e.mis});
                busy_run = 0;
            end
        end
    end

    task automatic wait_sb(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
        end
        chk({tag, "_timeout"}, 32'd1, 32'd0);
        sb.delete();
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] ei, input int eb,
                       input logic em, input string tag);
        @(posedge clk); #1;
        pc   = a;
        read = 1'b1;
        sb.push_back('{tag, ei, eb, em});
        wait_sb(tag);
    endtask

    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic drop_read();
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = 32'd6; read = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busywait}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; read = 1'b0; pc = 32'd0;

        load_byte(10'd0, 8'h03); load_byte(10'd1, 8'h00);
        load_byte(10'd2, 8'h00); load_byte(10'd3, 8'h00);
        load_byte(10'd4, 8'h05); load_byte(10'd5, 8'h00);
        load_byte(10'd6, 8'h01); load_byte(10'd7, 8'h00);

        req(32'd0, 32'h0000_0003, FETCH_LAT + 1, 1'b0, "miss0");
        req(32'd0, 32'h0000_0003, 0, 1'b0, "hit0");
        req(32'd6, 32'h0001_0005, FETCH_LAT + 1, 1'b1, "mis6");
        req(32'd4, 32'h0001_0005, 0, 1'b0, "hit4");
        req(32'd0, 32'h0000_0003, FETCH_LAT + 1, 1'b0, "b2b0");
        req(32'd4, 32'h0001_0005, FETCH_LAT + 1, 1'b0, "b2b4");
        req(32'd0, 32'h0000_0003, FETCH_LAT + 1, 1'b0, "buf0");

        // Writing into the buffered word must force a refetch of the new byte.
        drop_read();
        load_byte(10'd1, 8'hAA);
        req(32'd0, 32'h0000_AA03, FETCH_LAT + 1, 1'b0, "inval0");

        // Reset during the second fetch cycle aborts; held READ then refetches.
        @(posedge clk); #1;
        pc = 32'd4; read = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busywait}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_instr", instruction, 32'd0);
        reset = 1'b0;
        sb.push_back('{"refetch4", 32'h0001_0005, FETCH_LAT + 1, 1'b0});
        wait_sb("refetch4");

        req(32'h0000_0400, 32'h0000_AA03, FETCH_LAT + 1, 1'b0, "wrap400");
        req(32'd0, 32'h0000_AA03, 0, 1'b0, "wraphit0");

        // Two load cycles in IDLE with a miss pending stretch BUSYWAIT by two.
        @(posedge clk); #1;
        pc = 32'd4; read = 1'b1;
        load_en = 1'b1; load_addr = 10'd16; load_data = 8'h55;
        sb.push_back('{"ldconf", 32'h0001_0005, FETCH_LAT + 3, 1'b0});
        @(posedge clk); #1;
        load_addr = 10'd17;
        @(posedge clk); #1;
        load_en = 1'b0;
        wait_sb("ldconf");

        drop_read();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
